jtag_host: RTL

JTAG initiator that drives TCK/TMS/TDI and samples TDO to operate a JTAG TAP such as the on-chip DTM (dtm_jtag). A simple command/response interface, clocked on the system clock, requests TAP reset, IR scans, DR scans (up to DMI width) and idle clocks. It is used as the host-side model and bring-up driver for the debug transport.

---
 rtl/jtag_host.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator that drives tck/tms/tdi and samples tdo.
// Ports: cmd_valid/cmd_ready/cmd_op/cmd_len/cmd_data request a TAP
// operation; rsp_valid/rsp_data report completion and captured tdo;
// tck/tms/tdi/tdo/trst connect to the target TAP.
module jtag_host #(
  parameter int MAX_LEN = 41,
  parameter int DIV     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               trst
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = (LW > 3) ? LW : 3;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [6:0]    MAX7     = 7'(MAX_LEN);
  localparam logic [CW-1:0] MAXN     = CW'(MAX_LEN);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(5);

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_IDLE = 2'b11;

  typedef enum logic [2:0] {
    BOOT,
    READY,
    PRE,
    SHIFT,
    POST,
    IDLECLK,
    RSTSEQ,
    DONE
  } state_t;

  state_t             state;
  logic [PW-1:0]      phase;
  logic               high;
  logic [CW-1:0]      bitcnt;
  logic [CW-1:0]      n;
  logic               is_ir;
  logic [MAX_LEN-1:0] data;
  logic [MAX_LEN-1:0] cap;

  logic [CW-1:0] len_in;
  logic [CW-1:0] nxt;
  logic [CW-1:0] nm1;
  logic [CW-1:0] pre_last;
  logic          accept;
  logic          phase_end;

  assign len_in    = (cmd_len > MAX7) ? MAXN : CW'(cmd_len);
  assign nxt       = bitcnt + 1'b1;
  assign nm1       = n - 1'b1;
  assign pre_last  = is_ir ? CW'(3) : CW'(2);
  assign accept    = cmd_valid && cmd_ready;
  assign phase_end = (phase == PH_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      phase     <= '0;
      high      <= 1'b0;
      bitcnt    <= '0;
      n         <= '0;
      is_ir     <= 1'b0;
      data      <= '0;
      cap       <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      trst      <= 1'b0;
    end else begin
      trst      <= 1'b1;
      rsp_valid <= 1'b0;
      unique case (state)
        READY, DONE: begin
          if (accept) begin
            data   <= cmd_data;
            cap    <= '0;
            n      <= len_in;
            is_ir  <= (cmd_op == OP_IR);
            bitcnt <= '0;
            phase  <= '0;
            high   <= 1'b0;
            tck    <= 1'b0;
            tdi    <= 1'b0;
            if (cmd_op == OP_RST) begin
              state     <= RSTSEQ;
              tms       <= 1'b1;
              cmd_ready <= 1'b0;
            end else if (len_in == '0) begin
              // Empty scan or idle: finish without any TCK.
              state     <= DONE;
              tms       <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              cmd_ready <= 1'b1;
            end else if (cmd_op == OP_IDLE) begin
              state     <= IDLECLK;
              tms       <= 1'b0;
              cmd_ready <= 1'b0;
            end else begin
              state     <= PRE;
              tms       <= 1'b1;
              cmd_ready <= 1'b0;
            end
          end else if (state == DONE) begin
            state <= READY;
          end
        end
        default: begin
          if (!phase_end) begin
            phase <= phase + 1'b1;
          end else begin
            phase <= '0;
            if (!high) begin
              // Rising TCK: tdo has been stable since the
              // falling edge, so take it now.
              high <= 1'b1;
              tck  <= 1'b1;
              if (state == SHIFT) begin
                cap[bitcnt] <= tdo;
              end
            end else begin
              // End of bit: start the next low phase and
              // present the next tms/tdi with it.
              high <= 1'b0;
              tck  <= 1'b0;
              tdi  <= 1'b0;
              unique case (state)
                BOOT, RSTSEQ: begin
                  if (bitcnt == RST_LAST) begin
                    tms       <= 1'b0;
                    cmd_ready <= 1'b1;
                    if (state == BOOT) begin
                      state <= READY;
                    end else begin
                      state     <= DONE;
                      rsp_valid <= 1'b1;
                      rsp_data  <= '0;
                    end
                  end else begin
                    bitcnt <= nxt;
                    tms    <= (nxt != RST_LAST);
                  end
                end
                PRE: begin
                  if (bitcnt == pre_last) begin
                    state  <= SHIFT;
                    bitcnt <= '0;
                    tms    <= (n == CW'(1));
                    tdi    <= data[0];
                  end else begin
                    bitcnt <= nxt;
                    tms    <= is_ir ? (nxt < CW'(2)) : 1'b0;
                  end
                end
                SHIFT: begin
                  if (bitcnt == nm1) begin
                    state  <= POST;
                    bitcnt <= '0;
                    tms    <= 1'b1;
                  end else begin
                    bitcnt <= nxt;
                    tms    <= (nxt == nm1);
                    tdi    <= data[nxt];
                  end
                end
                POST: begin
                  tms <= 1'b0;
                  if (bitcnt == CW'(1)) begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_data  <= cap;
                    cmd_ready <= 1'b1;
                  end else begin
                    bitcnt <= nxt;
                  end
                end
                IDLECLK: begin
                  tms <= 1'b0;
                  if (bitcnt == nm1) begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    cmd_ready <= 1'b1;
                  end else begin
                    bitcnt <= nxt;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
